u232c_rx_word: RTL and testbench

Parametrised RS-232C receiver that deserialises 8-bit frames from the `rx` line and assembles `BYTES` consecutive bytes, first byte most significant, into one word. Completed words are buffered in a small FIFO with a valid/ready output. It is the successor to the single-byte `i232c` decoder and is used by the loader path that receives instruction words and end markers from the host. It adds:
- configurable word width and parity;
- framing, parity and overrun detection;
- inter-byte timeout resynchronisation.

---
 rtl/u232c_pkg.sv | 34 +++
 rtl/u232c_rx_word_fifo.sv | 58 +++++
 rtl/u232c_rx_word.sv | 205 ++++++++++++++++++++
 tb/tb_u232c_rx_word.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u232c_pkg.sv
// Shared types and constants for the u232c word receiver.
package u232c_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int ERR_FRAME   = 0;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_OVERRUN = 2;

  // True when the received parity bit disagrees with the configured mode.
  function automatic logic parity_fail(input logic [1:0] mode,
                                       input logic [7:0] data,
                                       input logic       pbit);
    logic odd_ones;
    odd_ones    = (^data) ^ pbit;
    parity_fail = 1'b0;
    if (mode == PAR_EVEN)
      parity_fail = odd_ones;
    else if (mode == PAR_ODD)
      parity_fail = ~odd_ones;
  endfunction

endpackage

// File: rtl/u232c_rx_word_fifo.sv
// Small synchronous FIFO holding completed words; push and pop in the
// same cycle are both honoured, even when full.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only visible through head when non-empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/u232c_rx_word.sv
// RS-232C receiver that assembles BYTES serial bytes (first byte most
// significant) into words and queues them in a valid/ready FIFO.
module u232c_rx_word
  import u232c_pkg::*;
#(
  parameter logic [15:0] WTIME        = 16'h0243,
  parameter int          BYTES        = 4,
  parameter int          DEPTH        = 4,
  parameter int          PARITY       = 0,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [7:0]         byte_data,
  output logic               byte_valid,
  output logic [8*BYTES-1:0] word_data,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               err_frame,
  output logic               err_parity,
  output logic               err_overrun,
  output logic [2:0]         err_sticky
);

  localparam int          W        = 8 * BYTES;
  localparam logic [1:0]  PAR_MODE = 2'(PARITY);
  localparam logic [3:0]  LAST_IDX = 4'(BYTES - 1);
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS) * 32'(WTIME);

  rx_state_t     state;
  logic          rx_meta;
  logic          rxs;
  logic [15:0]   cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [3:0]    idx;
  logic [W-1:0]  asm_word;
  logic [31:0]   to_cnt;
  logic          word_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  assign word_valid = !fifo_empty;
  assign fifo_pop   = word_valid && word_ready;

  // Two-flop synchronizer; resets low so ARM only leaves on a real high line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rxs     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM, byte assembler and inter-byte timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ARM;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      idx        <= '0;
      asm_word   <= '0;
      to_cnt     <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
      word_push  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
      word_push  <= 1'b0;

      if (TIMEOUT_BITS != 0 && state == ST_IDLE && idx != '0) begin
        if (to_cnt == TO_LIMIT - 32'd1) begin
          idx      <= '0;
          asm_word <= '0;
          to_cnt   <= '0;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end else begin
        to_cnt <= '0;
      end

      case (state)
        ST_ARM: begin
          if (rxs)
            state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            cnt   <= WTIME >> 1;
          end
        end

        ST_START: begin
          if (cnt == 16'd1) begin
            if (!rxs) begin
              state   <= ST_DATA;
              cnt     <= WTIME;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        ST_DATA: begin
          if (cnt == 16'd1) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= WTIME;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PAR;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        ST_PAR: begin
          if (cnt == 16'd1) begin
            par_bit <= rxs;
            cnt     <= WTIME;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        ST_STOP: begin
          if (cnt == 16'd1) begin
            if (!rxs) begin
              err_frame <= 1'b1;
              idx       <= '0;
              asm_word  <= '0;
              state     <= ST_ARM;
            end else if (parity_fail(PAR_MODE, shreg, par_bit)) begin
              err_parity <= 1'b1;
              idx        <= '0;
              asm_word   <= '0;
              state      <= ST_IDLE;
            end else begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              asm_word   <= (asm_word << 8) | W'(shreg);
              if (idx == LAST_IDX) begin
                idx       <= '0;
                word_push <= 1'b1;
              end else begin
                idx <= idx + 4'd1;
              end
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        default: state <= ST_ARM;
      endcase
    end
  end

  // Overrun pulse when a completed word meets a full FIFO with no pop,
  // and sticky accumulation of all error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overrun <= 1'b0;
      err_sticky  <= '0;
    end else begin
      err_overrun              <= word_push && fifo_full && !fifo_pop;
      err_sticky[ERR_FRAME]    <= err_sticky[ERR_FRAME]   | err_frame;
      err_sticky[ERR_PARITY]   <= err_sticky[ERR_PARITY]  | err_parity;
      err_sticky[ERR_OVERRUN]  <= err_sticky[ERR_OVERRUN] | err_overrun;
    end
  end

  word_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_push),
    .push_data (asm_word),
    .pop       (fifo_pop),
    .head      (word_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_u232c_rx_word.sv
// Bench for u232c_rx_word: table-driven frames, parity, overrun, timeout,
// reset corner cases and a randomized run against a word-assembly model.
module tb_u232c_rx_word;

  localparam int WT = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx0, rx1, ready0, ready1;
  logic [7:0]  bd0, bd1;
  logic        bv0, bv1;
  logic [31:0] wd0, wd1;
  logic        wv0, wv1;
  logic        ef0, ep0, eo0, ef1, ep1, eo1;
  logic [2:0]  es0, es1;

  always #5 clk = ~clk;

  u232c_rx_word #(.WTIME(16'd6), .BYTES(4), .DEPTH(4), .PARITY(0), .TIMEOUT_BITS(20)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .byte_data(bd0), .byte_valid(bv0),
    .word_data(wd0), .word_valid(wv0), .word_ready(ready0), .err_frame(ef0),
    .err_parity(ep0), .err_overrun(eo0), .err_sticky(es0));

  u232c_rx_word #(.WTIME(16'd6), .BYTES(4), .DEPTH(4), .PARITY(1), .TIMEOUT_BITS(20)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .byte_data(bd1), .byte_valid(bv1),
    .word_data(wd1), .word_valid(wv1), .word_ready(ready1), .err_frame(ef1),
    .err_parity(ep1), .err_overrun(eo1), .err_sticky(es1));

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  int  cyc = 0;
  int  bv_cnt0 = 0, ef_cnt0 = 0, ep_cnt0 = 0, eo_cnt0 = 0;
  int  last_bv_cyc0 = 0, wv_rise_cyc0 = 0;
  bit  wv_prev0 = 1'b0;
  int  bv_cnt1 = 0, ep_cnt1 = 0;
  logic [31:0] popped0[$];

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bv0) begin bv_cnt0++; last_bv_cyc0 = cyc; end
      if (ef0) ef_cnt0++;
      if (ep0) ep_cnt0++;
      if (eo0) eo_cnt0++;
      if (wv0 && !wv_prev0) wv_rise_cyc0 = cyc;
      if (wv0 && ready0) popped0.push_back(wd0);
      if (bv1) bv_cnt1++;
      if (ep1) ep_cnt1++;
    end
    wv_prev0 = wv0;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    bit          check_word;
    logic [31:0] word;
  } frame_vec_t;

  frame_vec_t vecs[9];

  int          exp_bv0 = 0, exp_ef0 = 0;
  logic [2:0]  exp_sticky0 = 3'b000;
  logic [7:0]  exp_bd0 = 8'h00;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic val);
    if (which == 0) rx0 = val;
    else            rx1 = val;
    wait_cycles(WT);
  endtask

  task automatic apply_stimulus(input int which, input logic [7:0] data, input bit use_par,
                                input logic pbit, input logic stop_bit);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
    if (use_par) drive_bit(which, pbit);
    drive_bit(which, stop_bit);
    drive_bit(which, 1'b1);
    drive_bit(which, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) apply_stimulus(0, w[8*b +: 8], 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop_one();
    ready0 = 1'b1;
    wait_cycles(1);
    ready0 = 1'b0;
  endtask

  task automatic check_popped(input string name, input int pos, input logic [31:0] expected);
    logic [31:0] v;
    v = 32'h0;
    if (popped0.size() > pos) v = popped0[pos];
    check_output(name, v, expected);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " word_valid"}, wv0, 0);
    check_output({tag, " word_data"}, wd0, 0);
    check_output({tag, " byte_valid"}, bv0, 0);
    check_output({tag, " byte_data"}, bd0, 0);
    check_output({tag, " err pulses"}, {ef0, ep0, eo0}, 0);
    check_output({tag, " err_sticky"}, es0, 0);
  endtask

  initial begin
    int          base;
    logic [31:0] words[5];
    logic [31:0] exp_words[$];
    logic [31:0] part;
    int          idx_m;
    logic [7:0]  d;
    bit          bad;
    logic [31:0] w;

    reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(5);
    check_reset_outputs("reset");
    check_output("reset dut1 outputs", {wv1, bv1, ef1, ep1, eo1, es1, bd1}, 0);

    // Good word, then a framing error, then another good word.
    vecs = '{
      '{8'hDE, 1'b1, 1'b0, 32'h0},
      '{8'hAD, 1'b1, 1'b0, 32'h0},
      '{8'hBE, 1'b1, 1'b0, 32'h0},
      '{8'hEF, 1'b1, 1'b1, 32'hDEADBEEF},
      '{8'h12, 1'b0, 1'b0, 32'h0},
      '{8'h01, 1'b1, 1'b0, 32'h0},
      '{8'h02, 1'b1, 1'b0, 32'h0},
      '{8'h03, 1'b1, 1'b0, 32'h0},
      '{8'h04, 1'b1, 1'b1, 32'h01020304}
    };
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop);
      if (vecs[i].stop) begin
        exp_bv0++;
        exp_bd0 = vecs[i].data;
        check_output("byte_data", bd0, exp_bd0);
      end else begin
        exp_ef0++;
        exp_sticky0[0] = 1'b1;
      end
      check_output("byte_valid count", bv_cnt0, exp_bv0);
      check_output("err_frame count", ef_cnt0, exp_ef0);
      check_output("err_sticky", es0, exp_sticky0);
      if (vecs[i].check_word) begin
        check_output("word_valid", wv0, 1);
        check_output("word_data", wd0, vecs[i].word);
        check_output("word latency after byte_valid", wv_rise_cyc0 - last_bv_cyc0, 1);
        base = popped0.size();
        pop_one();
        check_popped("popped word", base, vecs[i].word);
        check_output("word_valid after pop", wv0, 0);
        check_output("word_data after pop", wd0, 0);
      end else begin
        check_output("no word pending", wv0, 0);
      end
    end

    // Even parity on the second receiver: bad parity dropped, good one kept.
    apply_stimulus(1, 8'h03, 1'b1, 1'b1, 1'b1);
    check_output("parity err count", ep_cnt1, 1);
    check_output("parity byte dropped", bv_cnt1, 0);
    check_output("parity sticky", es1, 3'b010);
    apply_stimulus(1, 8'h03, 1'b1, 1'b0, 1'b1);
    check_output("parity ok byte_valid", bv_cnt1, 1);
    check_output("parity ok byte_data", bd1, 8'h03);
    check_output("parity err unchanged", ep_cnt1, 1);

    // Overrun: five words with no consumer, depth four.
    ready0 = 1'b0;
    for (int k = 0; k < 5; k++) words[k] = $urandom;
    for (int k = 0; k < 4; k++) send_word(words[k]);
    exp_bv0 += 16;
    check_output("full: word_valid", wv0, 1);
    check_output("full: head word", wd0, words[0]);
    check_output("full: no overrun yet", eo_cnt0, 0);
    send_word(words[4]);
    exp_bv0 += 4;
    check_output("overrun count", eo_cnt0, 1);
    check_output("overrun sticky", es0[2], 1);
    base = popped0.size();
    ready0 = 1'b1;
    for (int t = 0; t < 40 && wv0; t++) wait_cycles(1);
    ready0 = 1'b0;
    check_output("drain complete", wv0, 0);
    check_output("drain count", popped0.size() - base, 4);
    for (int k = 0; k < 4; k++) check_popped("drain order", base + k, words[k]);

    // Timeout: partial word discarded after a long idle gap.
    ready0 = 1'b1;
    base = popped0.size();
    apply_stimulus(0, 8'hAA, 1'b0, 1'b0, 1'b1);
    apply_stimulus(0, 8'hBB, 1'b0, 1'b0, 1'b1);
    wait_cycles(21 * WT);
    send_word(32'hFFFFFFFF);
    exp_bv0 += 6;
    wait_cycles(10);
    check_output("timeout word count", popped0.size() - base, 1);
    check_popped("timeout word", base, 32'hFFFFFFFF);
    check_output("timeout no frame error", ef_cnt0, exp_ef0);

    // Reset in the middle of DATA with the line low.
    ready0 = 1'b0;
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    check_reset_outputs("mid-frame reset");
    wait_cycles(4 * WT);
    check_output("low line not a start", bv_cnt0, exp_bv0);
    check_output("low line no frame error", ef_cnt0, exp_ef0);
    check_output("low line sticky", es0, 0);
    rx0 = 1'b1;
    wait_cycles(2 * WT);
    ready0 = 1'b1;
    base = popped0.size();
    w = $urandom;
    send_word(w);
    exp_bv0 += 4;
    wait_cycles(5);
    check_output("post-reset word count", popped0.size() - base, 1);
    check_popped("post-reset word", base, w);

    // Randomized frames against a word-assembly model; consumer always ready.
    base = popped0.size();
    idx_m = 0;
    part = 32'h0;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      apply_stimulus(0, d, 1'b0, 1'b0, !bad);
      if (bad) begin
        exp_ef0++;
        idx_m = 0;
        part = 32'h0;
      end else begin
        exp_bv0++;
        part = (part << 8) | 32'(d);
        idx_m++;
        if (idx_m == 4) begin
          exp_words.push_back(part);
          idx_m = 0;
        end
      end
    end
    wait_cycles(10);
    check_output("random byte count", bv_cnt0, exp_bv0);
    check_output("random frame errors", ef_cnt0, exp_ef0);
    check_output("random word count", popped0.size() - base, exp_words.size());
    for (int k = 0; k < exp_words.size(); k++) check_popped("random word", base + k, exp_words[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
